// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side port bundle for mem_lsu.
// master = the LSU itself, slave = the core plus data memory around it.
`timescale 1ns/1ps
interface mem_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_lsu.sv
// RV32I load/store unit driving a single-port word memory without byte enables.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
`timescale 1ns/1ps
module mem_lsu #(
   parameter int ADDR_W = 32
) (
   input logic    clk,
   input logic    rst_n,
   mem_lsu_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITE,
      RESP
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              store_q;
   logic [2:0]        funct3_q;
   logic [1:0]        offset_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       merged_q;
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic              accept;
   logic              funct3_ok;
   logic              misaligned;
   logic              legal;
   logic              word_store;
   logic              partial_store;

   function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
      logic ok;
      if (store) begin
         ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end else begin
         ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      return ok;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      logic [31:0] result;
      lane_b = word[{off, 3'b000} +: 8];
      lane_h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  result = {{24{lane_b[7]}}, lane_b};
         3'b100:  result = {24'h000000, lane_b};
         3'b001:  result = {{16{lane_h[15]}}, lane_h};
         3'b101:  result = {16'h0000, lane_h};
         default: result = word;
      endcase
      return result;
   endfunction

   // Byte/half lanes are patched into the word just read back so WRITE can store it whole.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] wdata);
      logic [31:0] result;
      result = word;
      if (f3[1:0] == 2'b00) begin
         result[{off, 3'b000} +: 8] = wdata[7:0];
      end else if (off[1]) begin
         result[31:16] = wdata[15:0];
      end else begin
         result[15:0] = wdata[15:0];
      end
      return result;
   endfunction

`ifdef LSU_MISALIGN_CHECK_EN
   assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign funct3_ok     = funct3_legal(bus.req_store, bus.req_funct3);
   assign legal         = funct3_ok && !misaligned;
   assign accept        = bus.req_valid && bus.req_ready;
   assign word_store    = store_q && (funct3_q[1:0] == 2'b10);
   assign partial_store = store_q && (funct3_q[1:0] != 2'b10);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = legal ? ACCESS : RESP;
            end
         end
         ACCESS:  state_next = partial_store ? WRITE : RESP;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // mem_we is decoded from state alone so an async reset drops it without waiting for an edge.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 32'h0;
      case (state)
         IDLE: begin
            bus.req_ready = rst_n;
         end
         ACCESS: begin
            if (word_store) begin
               bus.mem_we    = 1'b1;
               bus.mem_wdata = wdata_q;
            end
         end
         WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = merged_q;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
         end
         default: begin
            bus.mem_we = 1'b0;
         end
      endcase
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.mem_addr  = mem_addr_q;

   // Request capture; mem_addr only moves for legal requests so errors never touch the memory port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q    <= 1'b0;
         funct3_q   <= 3'b000;
         offset_q   <= 2'b00;
         wdata_q    <= 32'h0;
         err_q      <= 1'b0;
         merged_q   <= 32'h0;
         rdata_q    <= 32'h0;
         mem_addr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  store_q  <= bus.req_store;
                  funct3_q <= bus.req_funct3;
                  offset_q <= bus.req_addr[1:0];
                  wdata_q  <= bus.req_wdata;
                  err_q    <= !legal;
                  rdata_q  <= 32'h0;
                  if (legal) begin
                     mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            ACCESS: begin
               if (!store_q) begin
                  rdata_q <= load_extend(bus.mem_rdata, funct3_q, offset_q);
               end else begin
                  merged_q <= store_merge(bus.mem_rdata, funct3_q, offset_q, wdata_q);
               end
            end
            default: begin
               rdata_q <= rdata_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, abort/back-to-back sequences, then random traffic
// checked against a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_lsu;

   localparam int ADDR_W = 32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

   mem_lsu #(.ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // 64-byte data memory: combinational read, write at the rising edge.
   logic [31:0] mem_words [0:15] = '{default: 32'h0};
   assign bus.mem_rdata = mem_words[bus.mem_addr[5:2]];
   always @(posedge clk) begin
      if (bus.mem_we) mem_words[bus.mem_addr[5:2]] <= bus.mem_wdata;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          we_cnt;
      int          we_cycle;
   } result_t;

   typedef struct {
      string       name;
      bit          store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_we_cnt;
      int          exp_we_cycle;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   logic [7:0] ref_bytes [0:63] = '{default: 8'h00};

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s (bound expired)", name);
   endtask

   // Reference: memory as bytes, access size from funct3, extension by plain arithmetic.
   function automatic result_t modelRequest(input bit store, input logic [2:0] f3,
                                            input logic [31:0] addr, input logic [31:0] wdata);
      result_t r;
      int size;
      int base;
      bit ok;
      logic [31:0] val;
      r = '{32'h0, 1'b0, 0, 0, 0};
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (store) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else       ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_MISALIGN_CHECK_EN
      if (size > 1 && (addr % size) != 0) ok = 0;
`endif
      if (!ok) begin
         r.err = 1'b1;
         r.lat = 1;
         return r;
      end
      base = int'(addr[5:0]) - (int'(addr[5:0]) % size);
      if (store) begin
         for (int i = 0; i < size; i++) ref_bytes[base + i] = wdata[8*i +: 8];
         r.lat      = (size == 4) ? 2 : 3;
         r.we_cnt   = 1;
         r.we_cycle = (size == 4) ? 1 : 2;
      end else begin
         val = 32'h0;
         for (int i = 0; i < size; i++) val[8*i +: 8] = ref_bytes[base + i];
         if (!f3[2] && size == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
         if (!f3[2] && size == 2 && val[15]) val[31:16] = 16'hFFFF;
         r.rdata = val;
         r.lat   = 2;
      end
      return r;
   endfunction

   task automatic applyStimulus(input bit store, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output result_t got);
      int waited;
      got = '{32'h0, 1'b0, 0, 0, 0};
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = store;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      for (waited = 0; waited < 20 && !bus.req_ready; waited++) @(negedge clk);
      if (!bus.req_ready) begin
         reportFail("accept_timeout");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (bus.mem_we) begin
            got.we_cnt++;
            if (got.we_cycle == 0) got.we_cycle = c;
            checkOutput("mem_addr_on_we", bus.mem_addr, addr & 32'hFFFF_FFFC);
         end
         if (bus.rsp_valid) begin
            got.lat   = c;
            got.rdata = bus.rsp_rdata;
            got.err   = bus.rsp_err;
            break;
         end
      end
      @(negedge clk);
      checkOutput("rsp_single_pulse", 32'(bus.rsp_valid), 32'h0);
   endtask

   task automatic compareResult(input string name, input result_t got, input result_t exp);
      checkOutput({name, "_rdata"}, got.rdata, exp.rdata);
      checkOutput({name, "_err"}, 32'(got.err), 32'(exp.err));
      checkOutput({name, "_latency"}, got.lat, exp.lat);
      checkOutput({name, "_we_count"}, got.we_cnt, exp.we_cnt);
      checkOutput({name, "_we_cycle"}, got.we_cycle, exp.we_cycle);
   endtask

   // Start a request, then pull rst_n in the given cycle after accept (1 = ACCESS, 2 = WRITE).
   task automatic abortWithReset(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int abort_cycle, input logic we_before);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      checkOutput({name, "_ready"}, 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (abort_cycle - 1) begin
         @(posedge clk);
         #1;
      end
      checkOutput({name, "_we_before"}, 32'(bus.mem_we), 32'(we_before));
      rst_n = 1'b0;
      #1;
      checkOutput({name, "_we_async"}, 32'(bus.mem_we), 32'h0);
      checkOutput({name, "_addr_reset"}, bus.mem_addr, 32'h0);
      repeat (2) begin
         @(negedge clk);
         checkOutput({name, "_rsp_in_reset"}, 32'(bus.rsp_valid), 32'h0);
      end
      rst_n = 1'b1;
      #1;
      checkOutput({name, "_ready_after"}, 32'(bus.req_ready), 32'h1);
      repeat (3) begin
         @(negedge clk);
         checkOutput({name, "_no_rsp"}, 32'(bus.rsp_valid), 32'h0);
      end
   endtask

   vec_t    vecs [13];
   result_t got;
   result_t exp;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0]  = '{"sw_word",    1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1};
      vecs[1]  = '{"lw_word",    1'b0, 3'b010, 32'h4, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 0};
      vecs[2]  = '{"lb_7",       1'b0, 3'b000, 32'h7, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 0};
      vecs[3]  = '{"lbu_7",      1'b0, 3'b100, 32'h7, 32'h0,        32'h000000DE, 1'b0, 2, 0, 0};
      vecs[4]  = '{"lh_4",       1'b0, 3'b001, 32'h4, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 0};
      vecs[5]  = '{"lhu_6",      1'b0, 3'b101, 32'h6, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 0};
      vecs[6]  = '{"sb_5",       1'b1, 3'b000, 32'h5, 32'hABCDEF12, 32'h0,        1'b0, 3, 1, 2};
      vecs[7]  = '{"lw_after_sb",1'b0, 3'b010, 32'h4, 32'h0,        32'hDEAD12EF, 1'b0, 2, 0, 0};
      vecs[8]  = '{"sh_6",       1'b1, 3'b001, 32'h6, 32'h1234A5A5, 32'h0,        1'b0, 3, 1, 2};
      vecs[9]  = '{"lw_after_sh",1'b0, 3'b010, 32'h4, 32'h0,        32'hA5A512EF, 1'b0, 2, 0, 0};
`ifdef LSU_MISALIGN_CHECK_EN
      vecs[10] = '{"lw_6",       1'b0, 3'b010, 32'h6, 32'h0,        32'h0,        1'b1, 1, 0, 0};
`else
      vecs[10] = '{"lw_6",       1'b0, 3'b010, 32'h6, 32'h0,        32'hA5A512EF, 1'b0, 2, 0, 0};
`endif
      vecs[11] = '{"load_f3_011",1'b0, 3'b011, 32'h4, 32'h0,        32'h0,        1'b1, 1, 0, 0};
      vecs[12] = '{"store_f3_100",1'b1,3'b100, 32'h8, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0};

      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_mem_we", 32'(bus.mem_we), 32'h0);
      checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
      checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata, got);
         exp = '{vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_we_cnt, vecs[i].exp_we_cycle};
         compareResult(vecs[i].name, got, exp);
         void'(modelRequest(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata));
      end

      // Resets mid-SB (ACCESS) and mid-SH (WRITE) must leave word 0x4 untouched.
      abortWithReset("abort_sb_access", 3'b000, 32'h4, 32'h00000077, 1, 1'b0);
      applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, got);
      checkOutput("word_after_sb_abort", got.rdata, 32'hA5A512EF);
      abortWithReset("abort_sh_write", 3'b001, 32'h6, 32'h00005A5A, 2, 1'b1);
      applyStimulus(1'b0, 3'b010, 32'h4, 32'h0, got);
      checkOutput("word_after_sh_abort", got.rdata, 32'hA5A512EF);

      // req_valid held through RESP: second load is accepted on the first IDLE edge.
      begin
         int pulses;
         int second_at;
         logic [31:0] first_data;
         logic [31:0] second_data;
         pulses = 0;
         second_at = 0;
         first_data = 32'h0;
         second_data = 32'h0;
         @(negedge clk);
         bus.req_valid  = 1'b1;
         bus.req_store  = 1'b0;
         bus.req_funct3 = 3'b100;
         bus.req_addr   = 32'h7;
         @(posedge clk);
         #1;
         bus.req_funct3 = 3'b101;
         bus.req_addr   = 32'h6;
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
               pulses++;
               if (pulses == 1) first_data = bus.rsp_rdata;
               if (pulses == 2) begin
                  second_data = bus.rsp_rdata;
                  second_at = c;
                  bus.req_valid = 1'b0;
               end
            end
         end
         bus.req_valid = 1'b0;
         checkOutput("b2b_pulses", pulses, 2);
         checkOutput("b2b_first_data", first_data, 32'h000000A5);
         checkOutput("b2b_second_data", second_data, 32'h0000A5A5);
         checkOutput("b2b_second_cycle", second_at, 5);
      end

      for (int n = 0; n < 150; n++) begin
         bit          store;
         logic [2:0]  f3;
         logic [31:0] addr;
         logic [31:0] wdata;
         int          pick;
         store = 1'($urandom_range(0, 1));
         pick  = $urandom_range(0, 11);
         f3    = (pick < 8) ? 3'(pick) : (store ? 3'($urandom_range(0, 2)) : 3'b010);
         addr  = 32'($urandom_range(0, 63));
         wdata = $urandom;
         applyStimulus(store, f3, addr, wdata, got);
         exp = modelRequest(store, f3, addr, wdata);
         compareResult("random", got, exp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
